axis_c2h_pattern_gen: RTL and testbench
=======================================

Name: axis_c2h_pattern_gen

Overview:
Transmit-side counterpart of the H2C loopback path. It generates framed AXI-Stream packets into the XDMA C2H port so the host can DMA-read a known pattern without an H2C write first. A start pulse launches a run of N packets of a programmable byte length. Payload is a running 32-bit word counter, so the host can check every byte. The block sits between the control logic and the xdma_stream s_axis_c2h_*_0 interface, in the axi_clk domain.

Parameters:
C_DATA_WIDTH, 128, stream data width in bits; multiple of 32, minimum 32.
LEN_W, 16, width of the packet byte-length field.
CNT_W, 16, width of the packet-count field.
IPG, 0, idle cycles inserted between packets (0 = back-to-back).

Ports:
axi_clk  in  1  stream clock (xdma axi_aclk).
axi_reset  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; launches a run when idle.
pkt_bytes  in  LEN_W  bytes per packet; latched on accepted start.
pkt_count  in  CNT_W  packets per run; latched on accepted start.
seed  in  32  initial word-counter value; latched on accepted start.
abort  in  1  ends the run at the next packet boundary.
s_axis_c2h_tdata  out  C_DATA_WIDTH  payload.
s_axis_c2h_tkeep  out  C_DATA_WIDTH/8  byte enables.
s_axis_c2h_tlast  out  1  last beat of a packet.
s_axis_c2h_tvalid  out  1  beat valid.
s_axis_c2h_tready  in  1  sink ready.
busy  out  1  run in progress.
done  out  1  one-cycle pulse at end of run.
pkts_sent  out  CNT_W  packets completed in the current or last run.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, word counter 0. A reset mid-packet drops the packet immediately; no tlast is emitted.
- Definitions: W = C_DATA_WIDTH/32 lanes, B = C_DATA_WIDTH/8 bytes per beat.
  - beats per packet = ceil(pkt_bytes/B).
  - rem = pkt_bytes mod B.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE:
  - start=1 latches pkt_bytes, pkt_count and seed, clears pkts_sent, sets busy, and goes to SEND.
  - If either latched field is 0, go straight to FIN instead.
  - tvalid rises the cycle after start (1-cycle latency).
- SEND:
  - tvalid=1 continuously.
  - tdata/tkeep/tlast are held stable while tvalid & ~tready.
  - A beat advances only on tvalid & tready.
  - Lane l (bits 32l+31:32l) = wcnt + l, mod 2^32. wcnt starts at seed and adds W per accepted beat.
  - wcnt continues across packets within a run; it is not reset between packets.
  - tkeep: all ones, except on the last beat when rem!=0, where tkeep = (1<<rem)-1 (low bytes).
  - tlast=1 on the final beat only. A 1-beat packet has tlast on its first beat.
- On the handshake of a tlast beat, pkts_sent is incremented, then:
  - if pkts_sent+1 == pkt_count, or abort was seen, go to FIN;
  - else if IPG>0, go to GAP;
  - else stay in SEND. Back-to-back: the next packet's first beat is valid the very next cycle.
- GAP: tvalid=0 for exactly IPG cycles, then SEND.
- FIN: tvalid=0, done=1 for one cycle, busy=0, then IDLE. pkts_sent holds until the next accepted start.
- abort: sampled every cycle while busy and remembered in a sticky flag.
  - Never truncates a packet in flight.
  - Asserted in GAP: go to FIN.
  - Cleared on entry to IDLE.
- start while busy: ignored; latched fields unchanged.
- start and abort in the same IDLE cycle: start wins; the abort is ignored.
- The block never deasserts tvalid without a handshake (AXI-Stream rule).

Test Plan:
1. C_DATA_WIDTH=128; pkt_bytes=64, pkt_count=1, seed=0x100, tready=1 -> 4 beats:
   - beat 0 lanes = 0x100..0x103, beat 3 lanes = 0x10C..0x10F;
   - tkeep=0xFFFF on all beats, tlast on beat 3;
   - done 1 cycle after the beat-3 handshake; pkts_sent=1.
2. pkt_bytes=20, pkt_count=3, tready=1, IPG=0 -> 6 beats with no bubble between packets:
   - tkeep 0xFFFF then 0x000F on each packet;
   - packet 2 first lane = seed+8;
   - pkts_sent=3.
3. pkt_bytes=48, tready toggled 1010... -> tdata/tkeep/tlast unchanged across every stall cycle; exactly 3 handshakes, payload identical to the tready=1 run.
4. pkt_bytes=16, pkt_count=10, IPG=2; abort pulsed mid-way through packet 4 -> packet 4 completes with tlast; exactly 2 idle cycles between packets 1-4; pkts_sent=4, then done.
5. seed=0xFFFFFFFE, pkt_bytes=16 -> lanes = FFFFFFFE, FFFFFFFF, 00000000, 00000001 (wrap).
6. Edge cases:
   - pkt_count=0 -> no tvalid, done 1 cycle later;
   - start during busy -> no effect;
   - axi_reset asserted mid-packet -> tvalid=0 asynchronously, busy=0;
   - restart after reset -> clean packet.

Source files
------------

// File: rtl/axis_c2h_pattern_gen.sv
// axis_c2h_pattern_gen
// Generates framed AXI-Stream packets for the XDMA C2H port so the host can
// DMA-read a known pattern. A start pulse launches a run of pkt_count packets
// of pkt_bytes bytes each. Each 32-bit lane carries a running word counter
// that starts at seed and keeps counting across packets in the run.
//
// Ports:
//   axi_clk, axi_reset       stream clock, async active-high reset
//   start                    launches a run when idle (ignored while busy)
//   pkt_bytes/pkt_count/seed run parameters, latched on an accepted start
//   abort                    ends the run at the next packet boundary
//   s_axis_c2h_t*            AXI-Stream master towards the XDMA C2H port
//   busy, done, pkts_sent    run status
//
// Handshake: a beat is transferred on a cycle where tvalid & tready are both
// high. Once tvalid is raised, tdata/tkeep/tlast stay constant and tvalid
// stays high until that transfer happens; tready never affects them.
module axis_c2h_pattern_gen #(
  parameter int C_DATA_WIDTH = 128,
  parameter int LEN_W        = 16,
  parameter int CNT_W        = 16,
  parameter int IPG          = 0
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic                      start,
  input  logic [LEN_W-1:0]          pkt_bytes,
  input  logic [CNT_W-1:0]          pkt_count,
  input  logic [31:0]               seed,
  input  logic                      abort,
  output logic [C_DATA_WIDTH-1:0]   s_axis_c2h_tdata,
  output logic [C_DATA_WIDTH/8-1:0] s_axis_c2h_tkeep,
  output logic                      s_axis_c2h_tlast,
  output logic                      s_axis_c2h_tvalid,
  input  logic                      s_axis_c2h_tready,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          pkts_sent
);

  localparam int W     = C_DATA_WIDTH / 32;
  localparam int B     = C_DATA_WIDTH / 8;
  localparam int BSH   = $clog2(B);
  localparam int GAP_W = (IPG > 2) ? $clog2(IPG) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t             state, state_n;
  logic [LEN_W-1:0]   last_beat_q;
  logic [LEN_W-1:0]   beat_q;
  logic [BSH-1:0]     rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   pkts_q;
  logic [31:0]        wcnt;
  logic               abort_q;
  logic [GAP_W-1:0]   gap_q;

  logic               tvalid;
  logic               hs;
  logic               is_last;
  logic [LEN_W:0]     beats_n;
  logic [B-1:0]       keep_last;
  logic [B-1:0]       keep;
  logic [C_DATA_WIDTH-1:0] data;

  // ceil(pkt_bytes / B), computed one bit wider so the rounding add cannot wrap
  assign beats_n = ({1'b0, pkt_bytes} + (LEN_W+1)'(B - 1)) >> BSH;

  assign tvalid  = (state == SEND);
  assign hs      = tvalid & s_axis_c2h_tready;
  assign is_last = (beat_q == last_beat_q);

  always_comb begin
    data      = '0;
    keep_last = '0;
    for (int l = 0; l < W; l++) begin
      data[32*l +: 32] = wcnt + 32'(l);
    end
    for (int i = 0; i < B; i++) begin
      keep_last[i] = (BSH'(i) < rem_q);
    end
    // A partial final beat enables only its low rem bytes
    keep = (is_last && rem_q != '0) ? keep_last : '1;
  end

  // Payload fields are forced to zero whenever no beat is offered
  assign s_axis_c2h_tvalid = tvalid;
  assign s_axis_c2h_tdata  = tvalid ? data : '0;
  assign s_axis_c2h_tkeep  = tvalid ? keep : '0;
  assign s_axis_c2h_tlast  = tvalid & is_last;
  assign busy              = (state == SEND) || (state == GAP);
  assign done              = (state == FIN);
  assign pkts_sent         = pkts_q;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (pkt_bytes == '0 || pkt_count == '0) ? FIN : SEND;
        end
      end
      SEND: begin
        // abort is only acted on here, at the tlast handshake, so a packet
        // already started is always completed
        if (hs && is_last) begin
          if ((pkts_q + CNT_W'(1) == cnt_q) || abort_q || abort) begin
            state_n = FIN;
          end else if (IPG > 0) begin
            state_n = GAP;
          end else begin
            state_n = SEND;
          end
        end
      end
      GAP: begin
        if (abort_q || abort) begin
          state_n = FIN;
        end else if (gap_q == GAP_W'(IPG - 1)) begin
          state_n = SEND;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state       <= IDLE;
      last_beat_q <= '0;
      beat_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      pkts_q      <= '0;
      wcnt        <= '0;
      abort_q     <= 1'b0;
      gap_q       <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          abort_q <= 1'b0;
          if (start) begin
            last_beat_q <= LEN_W'(beats_n - (LEN_W+1)'(1));
            rem_q       <= pkt_bytes[BSH-1:0];
            cnt_q       <= pkt_count;
            wcnt        <= seed;
            pkts_q      <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
          end
        end
        SEND: begin
          if (abort) abort_q <= 1'b1;
          if (hs) begin
            wcnt <= wcnt + 32'(W);
            if (is_last) begin
              beat_q <= '0;
              pkts_q <= pkts_q + CNT_W'(1);
            end else begin
              beat_q <= beat_q + LEN_W'(1);
            end
          end
        end
        GAP: begin
          if (abort) abort_q <= 1'b1;
          gap_q <= (state_n == GAP) ? gap_q + GAP_W'(1) : '0;
        end
        FIN: begin
          abort_q <= 1'b0;
        end
        default: abort_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_c2h_pattern_gen.sv
// Testbench for axis_c2h_pattern_gen. Two instances share clock and reset:
// dut_a runs back-to-back (IPG=0), dut_b inserts two idle cycles (IPG=2).
module tb_axis_c2h_pattern_gen;

  localparam int DW = 128;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic axi_reset;

  logic          a_start, a_abort, a_tready;
  logic [15:0]   a_pkt_bytes, a_pkt_count;
  logic [31:0]   a_seed;
  logic [DW-1:0] a_tdata;
  logic [KW-1:0] a_tkeep;
  logic          a_tlast, a_tvalid, a_busy, a_done;
  logic [15:0]   a_pkts_sent;

  logic          b_start, b_abort, b_tready;
  logic [15:0]   b_pkt_bytes, b_pkt_count;
  logic [31:0]   b_seed;
  logic [DW-1:0] b_tdata;
  logic [KW-1:0] b_tkeep;
  logic          b_tlast, b_tvalid, b_busy, b_done;
  logic [15:0]   b_pkts_sent;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cap_data[$];
  logic [KW-1:0] cap_keep[$];
  logic          cap_last[$];
  int            cap_cyc[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  axis_c2h_pattern_gen #(.C_DATA_WIDTH(DW), .LEN_W(16), .CNT_W(16), .IPG(0)) dut_a (
    .axi_clk(clk), .axi_reset(axi_reset), .start(a_start), .pkt_bytes(a_pkt_bytes),
    .pkt_count(a_pkt_count), .seed(a_seed), .abort(a_abort),
    .s_axis_c2h_tdata(a_tdata), .s_axis_c2h_tkeep(a_tkeep), .s_axis_c2h_tlast(a_tlast),
    .s_axis_c2h_tvalid(a_tvalid), .s_axis_c2h_tready(a_tready),
    .busy(a_busy), .done(a_done), .pkts_sent(a_pkts_sent)
  );

  axis_c2h_pattern_gen #(.C_DATA_WIDTH(DW), .LEN_W(16), .CNT_W(16), .IPG(2)) dut_b (
    .axi_clk(clk), .axi_reset(axi_reset), .start(b_start), .pkt_bytes(b_pkt_bytes),
    .pkt_count(b_pkt_count), .seed(b_seed), .abort(b_abort),
    .s_axis_c2h_tdata(b_tdata), .s_axis_c2h_tkeep(b_tkeep), .s_axis_c2h_tlast(b_tlast),
    .s_axis_c2h_tvalid(b_tvalid), .s_axis_c2h_tready(b_tready),
    .busy(b_busy), .done(b_done), .pkts_sent(b_pkts_sent)
  );

  // Expected beat: four lanes counting up from base
  function automatic logic [DW-1:0] beat_of(input logic [31:0] base);
    logic [DW-1:0] r;
    for (int l = 0; l < DW / 32; l++) r[32*l +: 32] = base + 32'(l);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    axi_reset = 1'b1;
    a_start = 0; a_abort = 0; a_tready = 1; a_pkt_bytes = 0; a_pkt_count = 0; a_seed = 0;
    b_start = 0; b_abort = 0; b_tready = 1; b_pkt_bytes = 0; b_pkt_count = 0; b_seed = 0;
    repeat (3) @(posedge clk);
    #1 axi_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic kick(input bit sel, input logic [15:0] bytes, input logic [15:0] count,
                      input logic [31:0] seed, input logic ab);
    if (!sel) begin
      a_start = 1; a_pkt_bytes = bytes; a_pkt_count = count; a_seed = seed; a_abort = ab;
    end else begin
      b_start = 1; b_pkt_bytes = bytes; b_pkt_count = count; b_seed = seed; b_abort = ab;
    end
    @(posedge clk); #1;
    a_start = 0; a_abort = 0; b_start = 0; b_abort = 0;
  endtask

  // Records every handshake (tready held by caller) until done or budget runs out.
  // abort_at >= 0 pulses abort on dut_b while beat number abort_at is offered.
  task automatic capture(input bit sel, input int budget, input int abort_at,
                         output bit saw_done, output int done_cyc);
    logic v, d, l;
    logic [DW-1:0] dt;
    logic [KW-1:0] k;
    saw_done = 0; done_cyc = -1;
    cap_data.delete(); cap_keep.delete(); cap_last.delete(); cap_cyc.delete();
    for (int cyc = 0; cyc < budget; cyc++) begin
      v  = sel ? b_tvalid : a_tvalid;
      d  = sel ? b_done   : a_done;
      l  = sel ? b_tlast  : a_tlast;
      dt = sel ? b_tdata  : a_tdata;
      k  = sel ? b_tkeep  : a_tkeep;
      if (d) begin
        saw_done = 1; done_cyc = cyc;
        break;
      end
      b_abort = sel && v && (abort_at >= 0) && (cap_data.size() == abort_at);
      if (v && (sel ? b_tready : a_tready)) begin
        cap_data.push_back(dt); cap_keep.push_back(k);
        cap_last.push_back(l);  cap_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    a_abort = 0; b_abort = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({a_tvalid, a_tlast, a_busy, a_done} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {a_tvalid, a_tlast, a_busy, a_done});
    end
    n_vec++;
    if (a_tdata !== '0 || a_tkeep !== '0) begin
      n_err++; $display("FAIL reset_payload: got %h/%h expected 0/0", a_tdata, a_tkeep);
    end
    n_vec++;
    if (a_pkts_sent !== 16'd0 || b_pkts_sent !== 16'd0 || b_tvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_cnt: got %0d/%0d/%b expected 0/0/0", a_pkts_sent, b_pkts_sent, b_tvalid);
    end
  endtask

  task automatic test_single_packet();
    bit sd; int dc;
    a_tready = 1;
    kick(0, 16'd64, 16'd1, 32'h100, 0);
    capture(0, 20, -1, sd, dc);
    for (int i = 0; i < 4; i++) exp_q.push_back(beat_of(32'h100 + 32'(4 * i)));
    n_vec++;
    if (cap_data.size() != 4 || !sd) begin
      n_err++; $display("FAIL single_beats: got %0d beats done=%0d expected 4 beats done=1", cap_data.size(), sd);
    end
    for (int i = 0; i < cap_data.size() && exp_q.size() > 0; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (cap_data[i] !== e || cap_keep[i] !== 16'hFFFF || cap_last[i] !== (i == 3) || cap_cyc[i] != i) begin
        n_err++;
        $display("FAIL single_beat%0d: got %h keep %h last %b cyc %0d expected %h keep ffff last %b cyc %0d",
                 i, cap_data[i], cap_keep[i], cap_last[i], cap_cyc[i], e, (i == 3), i);
      end
    end
    exp_q.delete();
    n_vec++;
    if (dc != 4 || a_busy !== 1'b0 || a_pkts_sent !== 16'd1) begin
      n_err++; $display("FAIL single_done: got cyc %0d busy %b sent %0d expected 4 0 1", dc, a_busy, a_pkts_sent);
    end
    @(posedge clk); #1;
    n_vec++;
    if (a_done !== 1'b0 || a_pkts_sent !== 16'd1) begin
      n_err++; $display("FAIL single_done_pulse: got done %b sent %0d expected 0 1", a_done, a_pkts_sent);
    end
  endtask

  task automatic test_back_to_back();
    bit sd; int dc;
    a_tready = 1;
    kick(0, 16'd20, 16'd3, 32'h2000, 0);
    capture(0, 30, -1, sd, dc);
    for (int k = 0; k < 6; k++) exp_q.push_back(beat_of(32'h2000 + 32'(4 * k)));
    n_vec++;
    if (cap_data.size() != 6 || !sd || dc != 6) begin
      n_err++; $display("FAIL b2b_count: got %0d beats done=%0d at %0d expected 6 beats done at 6", cap_data.size(), sd, dc);
    end
    for (int k = 0; k < cap_data.size() && exp_q.size() > 0; k++) begin
      logic [DW-1:0] e;
      logic [KW-1:0] ek;
      e  = exp_q.pop_front();
      ek = (k % 2 == 1) ? 16'h000F : 16'hFFFF;
      n_vec++;
      if (cap_data[k] !== e || cap_keep[k] !== ek || cap_last[k] !== (k % 2 == 1) || cap_cyc[k] != k) begin
        n_err++;
        $display("FAIL b2b_beat%0d: got %h keep %h last %b cyc %0d expected %h keep %h last %b cyc %0d",
                 k, cap_data[k], cap_keep[k], cap_last[k], cap_cyc[k], e, ek, (k % 2 == 1), k);
      end
    end
    exp_q.delete();
    n_vec++;
    if (a_pkts_sent !== 16'd3) begin
      n_err++; $display("FAIL b2b_sent: got %0d expected 3", a_pkts_sent);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] s_data;
    logic [KW-1:0] s_keep;
    logic          s_last;
    bit have_snap, sd;
    int nh;
    have_snap = 0; sd = 0; nh = 0;
    kick(0, 16'd48, 16'd1, 32'h300, 0);
    for (int cyc = 0; cyc < 30; cyc++) begin
      a_tready = (cyc % 2 == 0);
      if (have_snap) begin
        n_vec++;
        if (a_tvalid !== 1'b1 || a_tdata !== s_data || a_tkeep !== s_keep || a_tlast !== s_last) begin
          n_err++; $display("FAIL bp_stall_cyc%0d: got v %b %h expected v 1 %h", cyc, a_tvalid, a_tdata, s_data);
        end
        have_snap = 0;
      end
      if (a_done) begin
        sd = 1;
        break;
      end
      if (a_tvalid && a_tready) begin
        n_vec++;
        if (a_tdata !== beat_of(32'h300 + 32'(4 * nh)) || a_tkeep !== 16'hFFFF || a_tlast !== (nh == 2)) begin
          n_err++; $display("FAIL bp_beat%0d: got %h last %b expected %h last %b",
                            nh, a_tdata, a_tlast, beat_of(32'h300 + 32'(4 * nh)), (nh == 2));
        end
        nh++;
      end else if (a_tvalid) begin
        s_data = a_tdata; s_keep = a_tkeep; s_last = a_tlast; have_snap = 1;
      end
      @(posedge clk); #1;
    end
    a_tready = 1;
    n_vec++;
    if (nh != 3 || !sd || a_pkts_sent !== 16'd1) begin
      n_err++; $display("FAIL bp_count: got %0d handshakes done=%0d sent %0d expected 3 1 1", nh, sd, a_pkts_sent);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort_ipg();
    bit sd; int dc;
    b_tready = 1;
    kick(1, 16'd16, 16'd10, 32'h4000, 0);
    capture(1, 60, 3, sd, dc);
    n_vec++;
    if (cap_data.size() != 4 || !sd || dc != 10) begin
      n_err++; $display("FAIL abort_count: got %0d beats done=%0d at %0d expected 4 beats done at 10", cap_data.size(), sd, dc);
    end
    for (int k = 0; k < cap_data.size() && k < 4; k++) begin
      n_vec++;
      if (cap_data[k] !== beat_of(32'h4000 + 32'(4 * k)) || cap_last[k] !== 1'b1 ||
          cap_keep[k] !== 16'hFFFF || cap_cyc[k] != 3 * k) begin
        n_err++;
        $display("FAIL abort_pkt%0d: got %h last %b cyc %0d expected %h last 1 cyc %0d",
                 k, cap_data[k], cap_last[k], cap_cyc[k], beat_of(32'h4000 + 32'(4 * k)), 3 * k);
      end
    end
    n_vec++;
    if (b_pkts_sent !== 16'd4 || b_busy !== 1'b0) begin
      n_err++; $display("FAIL abort_sent: got %0d busy %b expected 4 0", b_pkts_sent, b_busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    bit sd; int dc;
    logic [DW-1:0] e;
    e = {32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    a_tready = 1;
    kick(0, 16'd16, 16'd1, 32'hFFFFFFFE, 0);
    capture(0, 10, -1, sd, dc);
    n_vec++;
    if (cap_data.size() != 1 || !sd) begin
      n_err++; $display("FAIL wrap_count: got %0d beats done=%0d expected 1 1", cap_data.size(), sd);
    end else if (cap_data[0] !== e || cap_last[0] !== 1'b1 || cap_keep[0] !== 16'hFFFF) begin
      n_err++; $display("FAIL wrap_data: got %h last %b expected %h last 1", cap_data[0], cap_last[0], e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_count();
    kick(0, 16'd64, 16'd0, 32'h10, 0);
    n_vec++;
    if (a_tvalid !== 1'b0 || a_done !== 1'b1 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL zero_cnt_fin: got v %b done %b busy %b expected 0 1 0", a_tvalid, a_done, a_busy);
    end
    @(posedge clk); #1;
    n_vec++;
    if (a_tvalid !== 1'b0 || a_done !== 1'b0 || a_pkts_sent !== 16'd0) begin
      n_err++; $display("FAIL zero_cnt_idle: got v %b done %b sent %0d expected 0 0 0", a_tvalid, a_done, a_pkts_sent);
    end
  endtask

  task automatic test_start_while_busy();
    bit sd; int dc;
    a_tready = 0;
    kick(0, 16'd64, 16'd1, 32'h500, 0);
    @(posedge clk); #1;
    a_start = 1; a_pkt_bytes = 16'd16; a_pkt_count = 16'd5; a_seed = 32'h900;
    @(posedge clk); #1;
    a_start = 0;
    a_tready = 1;
    capture(0, 20, -1, sd, dc);
    n_vec++;
    if (cap_data.size() != 4 || !sd || a_pkts_sent !== 16'd1) begin
      n_err++; $display("FAIL busy_start_count: got %0d beats sent %0d expected 4 1", cap_data.size(), a_pkts_sent);
    end else if (cap_data[0] !== beat_of(32'h500) || cap_data[3] !== beat_of(32'h50C) || cap_last[3] !== 1'b1) begin
      n_err++; $display("FAIL busy_start_data: got %h..%h expected %h..%h",
                        cap_data[0], cap_data[3], beat_of(32'h500), beat_of(32'h50C));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_abort_same_cycle();
    bit sd; int dc;
    a_tready = 1;
    kick(0, 16'd16, 16'd2, 32'h60, 1);
    capture(0, 20, -1, sd, dc);
    n_vec++;
    if (cap_data.size() != 2 || !sd || a_pkts_sent !== 16'd2) begin
      n_err++; $display("FAIL start_abort: got %0d beats sent %0d expected 2 2", cap_data.size(), a_pkts_sent);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_packet();
    bit sd; int dc;
    a_tready = 0;
    kick(0, 16'd64, 16'd1, 32'h700, 0);
    @(posedge clk); #1;
    #2 axi_reset = 1'b1;
    #1;
    n_vec++;
    if (a_tvalid !== 1'b0 || a_busy !== 1'b0 || a_tlast !== 1'b0 || a_tdata !== '0) begin
      n_err++; $display("FAIL reset_mid: got v %b busy %b last %b expected 0 0 0", a_tvalid, a_busy, a_tlast);
    end
    @(posedge clk); #1;
    axi_reset = 1'b0;
    @(posedge clk); #1;
    a_tready = 1;
    kick(0, 16'd16, 16'd1, 32'h40, 0);
    capture(0, 10, -1, sd, dc);
    n_vec++;
    if (cap_data.size() != 1 || !sd || dc != 1) begin
      n_err++; $display("FAIL restart_count: got %0d beats done at %0d expected 1 at 1", cap_data.size(), dc);
    end else if (cap_data[0] !== beat_of(32'h40) || cap_last[0] !== 1'b1 || a_pkts_sent !== 16'd1) begin
      n_err++; $display("FAIL restart_data: got %h last %b sent %0d expected %h 1 1",
                        cap_data[0], cap_last[0], a_pkts_sent, beat_of(32'h40));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    axi_reset = 1'b1;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_backpressure();
    test_abort_ipg();
    test_wrap();
    test_zero_count();
    test_start_while_busy();
    test_start_abort_same_cycle();
    test_reset_mid_packet();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
